// File: rtl/rca_pkg.sv
// Shared definitions for the sequenced ripple-carry adder: datapath width
// and the controller state encoding.
package rca_pkg;

    // Datapath width; the ripple adder is built for exactly this many bits.
    localparam int RCA_WIDTH = 32;

    // Controller states: waiting for operands, letting the carry ripple,
    // presenting the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } rca_state_e;

endpackage : rca_pkg

// File: rtl/ripple_carry_32_bit.sv
// Purely combinational 32-bit ripple-carry adder built from a chain of
// full adders. The carry travels through every stage, so the caller must
// give the operands time to settle before sampling sum/cout.
module ripple_carry_32_bit
    import rca_pkg::*;
(
    input  logic [RCA_WIDTH-1:0] a,
    input  logic [RCA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [RCA_WIDTH-1:0] sum,
    output logic                 cout
);

    // carry[i] is the carry into bit i; carry[RCA_WIDTH] is the final carry out.
    logic [RCA_WIDTH:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < RCA_WIDTH; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[RCA_WIDTH];

endmodule : ripple_carry_32_bit

// File: rtl/rca32_seq_adder.sv
// Sequential wrapper around ripple_carry_32_bit: latches operands on an
// input handshake, holds them for SETTLE_CYCLES clocks while the carry
// ripples, then captures sum/cout/overflow and offers them on an output
// handshake. An accumulator (last captured sum) can replace operand A.
module rca32_seq_adder
    import rca_pkg::*;
#(
    parameter int WIDTH         = RCA_WIDTH, // must stay 32 to match the adder
    parameter int SETTLE_CYCLES = 4,         // 1..255
    parameter int CNT_W         = 8          // must hold SETTLE_CYCLES-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    // Counter reload: the SETTLE state lasts cnt+1 cycles, so load N-1.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    rca_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // The operand registers feed the adder directly, so its inputs never
    // move while a transaction is settling.
    ripple_carry_32_bit u_adder (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (op_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in SETTLE, wait for the
    // consumer in HOLD. Everything defaults to holding its value.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d   = acc_en ? acc_q : a;
                    op_b_d   = b;
                    op_cin_d = cin;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    sum_d       = add_sum;
                    cout_d      = add_cout;
                    // Signed overflow: like-signed operands, result sign differs.
                    ovf_d       = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
                    acc_d       = add_sum;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule : rca32_seq_adder
